des_expand_keymix: RTL

//  Upstream feed stage of the DES f-function: takes the 32-bit right half R and the 48-bit round subkey,

---
 rtl/des_expand_keymix.sv | 109 ++++++++++
 1 files changed

// File: rtl/des_expand_keymix.sv
// DES f-function feed stage: E-expansion of R, XOR with the round subkey, registered into a 2-entry skid buffer.
// Optional macro DES_KEYMIX_BYPASS_EN adds key_bypass, which stores E(R) with the subkey ignored.
module des_expand_keymix #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [31:0]      r_in,
    input  logic [47:0]      subkey,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             in_valid,
`ifdef DES_KEYMIX_BYPASS_EN
    input  logic             key_bypass,
`endif
    output logic             in_ready,
    output logic [47:0]      sbox_in,
    output logic [TAG_W-1:0] tag_out,
    output logic             out_valid,
    input  logic             out_ready
);

    // Each S-box chunk k takes R bits 4k..4k+5 (DES numbering, wrapping 0->32 and 33->1).
    function automatic logic [47:0] e_expand(input logic [31:0] r);
        return {r[0],    r[31:27], r[28:23], r[24:19], r[20:15],
                r[16:11], r[12:7],  r[8:3],   r[4:0],   r[31]};
    endfunction

    logic [47:0]      key_s;
    logic [47:0]      mix_s;
    logic             in_xfer_s;
    logic             out_xfer_s;

    logic [47:0]      m_data_q, m_data_d;
    logic [TAG_W-1:0] m_tag_q,  m_tag_d;
    logic             m_valid_q, m_valid_d;
    logic [47:0]      s_data_q, s_data_d;
    logic [TAG_W-1:0] s_tag_q,  s_tag_d;
    logic             s_valid_q, s_valid_d;

`ifdef DES_KEYMIX_BYPASS_EN
    assign key_s = key_bypass ? 48'h0000_0000_0000 : subkey;
`else
    assign key_s = subkey;
`endif

    assign mix_s      = e_expand(r_in) ^ key_s;
    assign in_ready   = ~s_valid_q;
    assign out_valid  = m_valid_q;
    assign sbox_in    = m_data_q;
    assign tag_out    = m_tag_q;
    assign in_xfer_s  = in_valid & ~s_valid_q;
    assign out_xfer_s = m_valid_q & out_ready;

    // Next-state for main and skid entries; flush overrides every transfer.
    always_comb begin
        m_data_d  = m_data_q;
        m_tag_d   = m_tag_q;
        m_valid_d = m_valid_q;
        s_data_d  = s_data_q;
        s_tag_d   = s_tag_q;
        s_valid_d = s_valid_q;
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (out_xfer_s && s_valid_q) begin
            m_data_d  = s_data_q;
            m_tag_d   = s_tag_q;
            s_valid_d = 1'b0;
        end else if (out_xfer_s) begin
            if (in_xfer_s) begin
                m_data_d = mix_s;
                m_tag_d  = tag_in;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (in_xfer_s && m_valid_q) begin
            s_data_d  = mix_s;
            s_tag_d   = tag_in;
            s_valid_d = 1'b1;
        end else if (in_xfer_s) begin
            m_data_d  = mix_s;
            m_tag_d   = tag_in;
            m_valid_d = 1'b1;
        end else begin
            m_valid_d = m_valid_q;
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data_q  <= 48'h0000_0000_0000;
            m_tag_q   <= {TAG_W{1'b0}};
            m_valid_q <= 1'b0;
            s_data_q  <= 48'h0000_0000_0000;
            s_tag_q   <= {TAG_W{1'b0}};
            s_valid_q <= 1'b0;
        end else begin
            m_data_q  <= m_data_d;
            m_tag_q   <= m_tag_d;
            m_valid_q <= m_valid_d;
            s_data_q  <= s_data_d;
            s_tag_q   <= s_tag_d;
            s_valid_q <= s_valid_d;
        end
    end

endmodule
